// File: rtl/pp_mul_pkg.sv
// Shared widths, rounding/saturation constants and parameter-legality helpers
// for the pipelined multiplier.
package pp_mul_pkg;

    localparam int MAXW = 128;

    function automatic int result_width(input int a_w, input int b_w,
                                        input int acc_en, input int acc_guard);
        return a_w + b_w + ((acc_en != 0) ? acc_guard : 0);
    endfunction

    // Half an output LSB, added before the right shift so ties round up.
    function automatic logic [MAXW-1:0] round_const(input int shift);
        logic [MAXW-1:0] v;
        v = '0;
        if (shift > 0) v[shift-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [MAXW-1:0] sat_max(input int p_w, input bit sgn);
        logic [MAXW-1:0] v;
        v = '0;
        for (int i = 0; i < MAXW; i++)
            if (i < p_w - (sgn ? 1 : 0)) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [MAXW-1:0] sat_min(input int p_w, input bit sgn);
        logic [MAXW-1:0] v;
        v = '0;
        if (sgn) v[p_w-1] = 1'b1;
        return v;
    endfunction

    function automatic bit stage_ok(input int n);
        return (n >= 3) && (n <= 8);
    endfunction

    function automatic bit shift_ok(input int shift, input int rw);
        return (shift >= 0) && (shift < rw);
    endfunction

    function automatic bit width_ok(input int rw, input int p_w);
        return (rw + 1 <= MAXW) && (p_w >= 1) && (p_w <= MAXW);
    endfunction

endpackage

// File: rtl/pp_mul_postproc.sv
// Round-half-up right shift, then saturate or wrap into P_W bits with overflow flag.
// Latency: combinational; the parent registers the result in its last stage.
// Backpressure: none, purely combinational.
module pp_mul_postproc
    import pp_mul_pkg::*;
#(
    parameter int IN_W      = 22,
    parameter int IN_SIGNED = 0,
    parameter int SHIFT     = 0,
    parameter int SATURATE  = 0,
    parameter int P_W       = 22
) (
    input  logic [IN_W-1:0] i_x,
    output logic [P_W-1:0]  o_y,
    output logic            o_ovf
);

    // One extra bit so the rounding add can never carry out.
    localparam int EW = IN_W + 1;
    localparam logic [MAXW-1:0] RND_FULL = round_const(SHIFT);
    localparam logic [MAXW-1:0] MAX_FULL = sat_max(P_W, IN_SIGNED != 0);
    localparam logic [MAXW-1:0] MIN_FULL = sat_min(P_W, IN_SIGNED != 0);

    logic [EW-1:0]  w_xe;
    logic [EW-1:0]  w_sum;
    logic [EW-1:0]  w_r;
    logic [P_W-1:0] w_fit;
    logic           w_hi_ovf;

    assign w_xe  = (IN_SIGNED != 0) ? {i_x[IN_W-1], i_x} : {1'b0, i_x};
    assign w_sum = w_xe + RND_FULL[EW-1:0];

    always_comb begin
        w_r = w_xe;
        if (SHIFT > 0) begin
            if (IN_SIGNED != 0) w_r = $signed(w_sum) >>> SHIFT;
            else                w_r = w_sum >> SHIFT;
        end
    end

    generate
        if (P_W >= EW) begin : g_wide
            always_comb begin
                if (IN_SIGNED != 0) w_fit = P_W'($signed(w_r));
                else                w_fit = P_W'(w_r);
            end
            assign w_hi_ovf = 1'b0;
        end else begin : g_narrow
            assign w_fit = w_r[P_W-1:0];
            if (IN_SIGNED != 0) begin : g_sgn
                assign w_hi_ovf = !((&w_r[EW-1:P_W-1]) || (~|w_r[EW-1:P_W-1]));
            end else begin : g_uns
                assign w_hi_ovf = |w_r[EW-1:P_W];
            end
        end
    endgenerate

    always_comb begin
        o_y = w_fit;
        if ((SATURATE != 0) && w_hi_ovf)
            o_y = ((IN_SIGNED != 0) && w_r[EW-1]) ? MIN_FULL[P_W-1:0] : MAX_FULL[P_W-1:0];
    end

    assign o_ovf = w_hi_ovf;

endmodule

// File: rtl/pp_pipeline_accel_mul_pipe.sv
// Pipelined integer multiplier / MAC with rounding, saturation and overflow flag.
// Latency: NUM_STAGE ce=1 edges from accepted input to out_valid.
// Backpressure: none; ce=0 freezes every register, outputs hold.
module pp_pipeline_accel_mul_pipe
    import pp_mul_pkg::*;
#(
    parameter int A_W       = 11,
    parameter int B_W       = 11,
    parameter int P_W       = 22,
    parameter int NUM_STAGE = 4,
    parameter int SIGNED_A  = 0,
    parameter int SIGNED_B  = 0,
    parameter int SHIFT     = 0,
    parameter int SATURATE  = 0,
    parameter int ACC_EN    = 0,
    parameter int ACC_GUARD = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce,
    input  logic           in_valid,
    input  logic           in_first,
    input  logic           in_last,
    input  logic [A_W-1:0] din0,
    input  logic [B_W-1:0] din1,
    output logic [P_W-1:0] dout,
    output logic           out_valid,
    output logic           out_ovf
);

    localparam int FW = A_W + B_W;
    localparam int RW = result_width(A_W, B_W, ACC_EN, ACC_GUARD);
    localparam int RS = ((SIGNED_A != 0) || (SIGNED_B != 0)) ? 1 : 0;

    generate
        if (!stage_ok(NUM_STAGE)) begin : g_bad_stage
            $error("NUM_STAGE must lie in 3..8");
        end
        if (!shift_ok(SHIFT, RW)) begin : g_bad_shift
            $error("SHIFT must be below the result width");
        end
        if (!width_ok(RW, P_W)) begin : g_bad_width
            $error("result or output width out of range");
        end
    endgenerate

    logic [A_W-1:0] r_a;
    logic [B_W-1:0] r_b;
    logic           r_v1;
    logic           r_f1;
    logic           r_l1;

    // Index s holds the value leaving stage s; index 2 is the product/accumulator.
    logic [RW-1:0]          r_pd_dat [2:NUM_STAGE-1];
    logic [NUM_STAGE-1:2]   r_pd_vld;

    logic [A_W:0]           w_a_ext;
    logic [B_W:0]           w_b_ext;
    logic signed [FW+1:0]   w_full;
    logic [RW-1:0]          w_prod_ext;
    logic [RW-1:0]          w_last_dat;
    logic                   w_last_vld;
    logic [P_W-1:0]         w_pp_y;
    logic                   w_pp_ovf;

    assign w_a_ext    = (SIGNED_A != 0) ? {r_a[A_W-1], r_a} : {1'b0, r_a};
    assign w_b_ext    = (SIGNED_B != 0) ? {r_b[B_W-1], r_b} : {1'b0, r_b};
    assign w_full     = $signed(w_a_ext) * $signed(w_b_ext);
    // w_full is non-negative when both operands are unsigned, so sign extension is safe.
    assign w_prod_ext = RW'(w_full);

    assign w_last_dat = r_pd_dat[NUM_STAGE-1];
    assign w_last_vld = r_pd_vld[NUM_STAGE-1];

    pp_mul_postproc #(
        .IN_W      (RW),
        .IN_SIGNED (RS),
        .SHIFT     (SHIFT),
        .SATURATE  (SATURATE),
        .P_W       (P_W)
    ) u_postproc (
        .i_x   (w_last_dat),
        .o_y   (w_pp_y),
        .o_ovf (w_pp_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_v1      <= 1'b0;
            r_f1      <= 1'b0;
            r_l1      <= 1'b0;
            for (int s = 2; s < NUM_STAGE; s++) r_pd_dat[s] <= '0;
            r_pd_vld  <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (ce) begin
            r_a  <= din0;
            r_b  <= din1;
            r_v1 <= in_valid;
            r_f1 <= in_first;
            r_l1 <= in_last;

            if (r_v1)
                r_pd_dat[2] <= ((ACC_EN != 0) && !r_f1) ? r_pd_dat[2] + w_prod_ext : w_prod_ext;
            // In MAC mode only the closing term of a sum produces an output.
            r_pd_vld[2] <= r_v1 && ((ACC_EN == 0) || r_l1);

            for (int s = 3; s < NUM_STAGE; s++) begin
                r_pd_dat[s] <= r_pd_dat[s-1];
                r_pd_vld[s] <= r_pd_vld[s-1];
            end

            out_valid <= w_last_vld;
            out_ovf   <= w_last_vld && w_pp_ovf;
            if (w_last_vld) dout <= w_pp_y;
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_mul_pipe.sv
// Directed bench over several parameterisations with a per-instance expected-result queue.
module tb_pp_pipeline_accel_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        ce0;
    logic [10:0] a0, b0;
    logic [7:0]  a [1:6];
    logic [7:0]  b [1:6];
    logic        v [0:6];
    logic        f [0:6];
    logic        l [0:6];
    logic        vo [0:6];
    logic        of [0:6];
    logic [21:0] d0;
    logic [15:0] d1, d2, d3, d6;
    logic [7:0]  d4, d5;

    typedef struct {
        logic [31:0] dat;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t        q [7][$];
    int          cnt [7] = '{default: 0};
    int          ns  [7] = '{4, 3, 4, 4, 5, 8, 4};
    int          pw  [7] = '{22, 16, 16, 16, 8, 8, 16};
    logic [31:0] last [7] = '{default: 32'd0};
    int          n_chk = 0;
    int          n_fail = 0;

    pp_pipeline_accel_mul_pipe u0 (
        .clk(clk), .reset_n(reset_n), .ce(ce0), .in_valid(v[0]), .in_first(f[0]), .in_last(l[0]),
        .din0(a0), .din1(b0), .dout(d0), .out_valid(vo[0]), .out_ovf(of[0]));
    pp_pipeline_accel_mul_pipe #(.A_W(8), .B_W(8), .P_W(16), .NUM_STAGE(3), .SIGNED_A(1), .SIGNED_B(1)) u1 (
        .clk(clk), .reset_n(reset_n), .ce(1'b1), .in_valid(v[1]), .in_first(f[1]), .in_last(l[1]),
        .din0(a[1]), .din1(b[1]), .dout(d1), .out_valid(vo[1]), .out_ovf(of[1]));
    pp_pipeline_accel_mul_pipe #(.A_W(8), .B_W(8), .P_W(16), .SHIFT(4)) u2 (
        .clk(clk), .reset_n(reset_n), .ce(1'b1), .in_valid(v[2]), .in_first(f[2]), .in_last(l[2]),
        .din0(a[2]), .din1(b[2]), .dout(d2), .out_valid(vo[2]), .out_ovf(of[2]));
    pp_pipeline_accel_mul_pipe #(.A_W(8), .B_W(8), .P_W(16), .SHIFT(4), .SIGNED_A(1), .SIGNED_B(1)) u3 (
        .clk(clk), .reset_n(reset_n), .ce(1'b1), .in_valid(v[3]), .in_first(f[3]), .in_last(l[3]),
        .din0(a[3]), .din1(b[3]), .dout(d3), .out_valid(vo[3]), .out_ovf(of[3]));
    pp_pipeline_accel_mul_pipe #(.A_W(8), .B_W(8), .P_W(8), .NUM_STAGE(5), .SIGNED_A(1), .SIGNED_B(1), .SATURATE(1)) u4 (
        .clk(clk), .reset_n(reset_n), .ce(1'b1), .in_valid(v[4]), .in_first(f[4]), .in_last(l[4]),
        .din0(a[4]), .din1(b[4]), .dout(d4), .out_valid(vo[4]), .out_ovf(of[4]));
    pp_pipeline_accel_mul_pipe #(.A_W(8), .B_W(8), .P_W(8), .NUM_STAGE(8), .SIGNED_A(1), .SIGNED_B(1), .SATURATE(0)) u5 (
        .clk(clk), .reset_n(reset_n), .ce(1'b1), .in_valid(v[5]), .in_first(f[5]), .in_last(l[5]),
        .din0(a[5]), .din1(b[5]), .dout(d5), .out_valid(vo[5]), .out_ovf(of[5]));
    pp_pipeline_accel_mul_pipe #(.A_W(8), .B_W(8), .P_W(16), .ACC_EN(1), .ACC_GUARD(8)) u6 (
        .clk(clk), .reset_n(reset_n), .ce(1'b1), .in_valid(v[6]), .in_first(f[6]), .in_last(l[6]),
        .din0(a[6]), .din1(b[6]), .dout(d6), .out_valid(vo[6]), .out_ovf(of[6]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Counts the edges on which each instance's registers actually advance.
    always @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 7; i++)
                if (i != 0 || ce0) cnt[i] <= cnt[i] + 1;
        end
    end

    task automatic push(input int i, input int val, input logic o);
        exp_t        e;
        logic [31:0] m;
        m     = (32'h1 << pw[i]) - 32'h1;
        e.dat = 32'(val) & m;
        e.ovf = o;
        e.due = cnt[i] + ns[i];
        q[i].push_back(e);
    endtask

    task automatic mon(input int i, input logic vld, input logic [31:0] d, input logic o);
        exp_t e;
        if (vld) begin
            check($sformatf("u%0d_valid_expected", i), 32'(q[i].size() != 0), 32'd1);
            if (q[i].size() != 0) begin
                e = q[i].pop_front();
                check($sformatf("u%0d_dout", i), d, e.dat);
                check($sformatf("u%0d_ovf", i), 32'(o), 32'(e.ovf));
                check($sformatf("u%0d_latency_edge", i), 32'(cnt[i]), 32'(e.due));
                last[i] = e.dat;
            end
        end else begin
            check($sformatf("u%0d_ovf_idle", i), 32'(o), 32'd0);
            check($sformatf("u%0d_dout_hold", i), d, last[i]);
        end
    endtask

    always @(negedge clk) begin
        mon(0, vo[0], 32'(d0), of[0]);
        mon(1, vo[1], 32'(d1), of[1]);
        mon(2, vo[2], 32'(d2), of[2]);
        mon(3, vo[3], 32'(d3), of[3]);
        mon(4, vo[4], 32'(d4), of[4]);
        mon(5, vo[5], 32'(d5), of[5]);
        mon(6, vo[6], 32'(d6), of[6]);
    end

    task automatic drv8(input int i, input int x, input int y, input bit fi, input bit la,
                        input bit pu, input int ev, input bit eo);
        a[i] = x[7:0];
        b[i] = y[7:0];
        v[i] = 1'b1;
        f[i] = fi;
        l[i] = la;
        if (pu) push(i, ev, eo);
        @(negedge clk);
        v[i] = 1'b0;
        f[i] = 1'b0;
        l[i] = 1'b0;
    endtask

    initial begin
        int k;
        reset_n = 1'b1;
        ce0 = 1'b1;
        a0 = '0;
        b0 = '0;
        for (int i = 0; i < 7; i++) begin
            v[i] = 1'b0;
            f[i] = 1'b0;
            l[i] = 1'b0;
        end
        for (int i = 1; i < 7; i++) begin
            a[i] = '0;
            b[i] = '0;
        end

        #1 reset_n = 1'b0;
        #1;
        check("reset_out_valid", 32'(vo[0]), 32'd0);
        check("reset_dout", 32'(d0), 32'd0);
        check("reset_out_ovf", 32'(of[0]), 32'd0);
        check("reset_mac_dout", 32'(d6), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Full-scale unsigned product, then two samples separated by a bubble.
        a0 = 11'd2047; b0 = 11'd2047; v[0] = 1'b1; push(0, 4190209, 1'b0);
        @(negedge clk);
        a0 = 11'd1; b0 = 11'd1; push(0, 1, 1'b0);
        @(negedge clk);
        v[0] = 1'b0;
        @(negedge clk);
        a0 = 11'd3; b0 = 11'd5; v[0] = 1'b1; push(0, 15, 1'b0);
        @(negedge clk);
        v[0] = 1'b0;

        drv8(1, -3, 5, 0, 0, 1, -15, 0);
        drv8(1, -128, -128, 0, 0, 1, 16384, 0);
        drv8(1, 127, -128, 0, 0, 1, -16256, 0);

        drv8(2, 4, 6, 0, 0, 1, 2, 0);
        drv8(2, 23, 1, 0, 0, 1, 1, 0);
        drv8(2, 8, 1, 0, 0, 1, 1, 0);
        drv8(2, 255, 255, 0, 0, 1, 4064, 0);

        drv8(3, -4, 6, 0, 0, 1, -1, 0);
        drv8(3, -5, 5, 0, 0, 1, -2, 0);
        drv8(3, -1, 8, 0, 0, 1, 0, 0);

        drv8(4, 100, 100, 0, 0, 1, 127, 1);
        drv8(4, -100, 100, 0, 0, 1, -128, 1);
        drv8(4, 5, -6, 0, 0, 1, -30, 0);
        drv8(4, 127, 1, 0, 0, 1, 127, 0);
        drv8(4, -128, 1, 0, 0, 1, -128, 0);

        drv8(5, 100, 100, 0, 0, 1, 16, 1);
        drv8(5, -2, 3, 0, 0, 1, -6, 0);
        drv8(5, -128, 1, 0, 0, 1, -128, 0);

        drv8(6, 2, 3, 1, 0, 0, 0, 0);
        drv8(6, 4, 5, 0, 0, 0, 0, 0);
        drv8(6, 1, 1, 0, 1, 1, 27, 0);
        drv8(6, 7, 7, 1, 1, 1, 49, 0);
        repeat (12) @(negedge clk);

        // Three stalled cycles mid-flight must add exactly three cycles.
        a0 = 11'd10; b0 = 11'd20; v[0] = 1'b1; push(0, 200, 1'b0);
        @(negedge clk);
        v[0] = 1'b0;
        @(negedge clk);
        ce0 = 1'b0;
        repeat (3) @(negedge clk);
        ce0 = 1'b1;
        k = 0;
        while (!vo[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("stall_total_edges", 32'(5 + k), 32'd7);
        check("stall_dout", 32'(d0), 32'd200);
        repeat (4) @(negedge clk);

        // Reset while two samples are still inside the pipe.
        a0 = 11'd5; b0 = 11'd5; v[0] = 1'b1; push(0, 25, 1'b0);
        @(negedge clk);
        a0 = 11'd6; b0 = 11'd6; push(0, 36, 1'b0);
        @(negedge clk);
        a0 = 11'd7; b0 = 11'd7; push(0, 49, 1'b0);
        @(negedge clk);
        v[0] = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        q[0].delete();
        for (int i = 0; i < 7; i++) last[i] = 32'd0;
        #1;
        check("async_rst_out_valid", 32'(vo[0]), 32'd0);
        check("async_rst_dout", 32'(d0), 32'd0);
        check("async_rst_out_ovf", 32'(of[0]), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        // A non-first term right after reset accumulates onto zero.
        drv8(6, 3, 3, 0, 1, 1, 9, 0);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 7; i++)
            check($sformatf("u%0d_outstanding", i), 32'(q[i].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
